// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings,
// the x0 register index, the stage-register bubble encoding and control helpers.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } ctrl_state_e;

    localparam logic [4:0]  REG_X0     = 5'd0;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          WAIT_CNT_W = 8;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctrl_t;

    function automatic stage_ctrl_t ctrl_advance();
        return '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1, ex_mem_we: 1'b1,
                 if_id_flush: 1'b0, id_ex_flush: 1'b0};
    endfunction

    function automatic stage_ctrl_t ctrl_freeze();
        return '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0, ex_mem_we: 1'b0,
                 if_id_flush: 1'b0, id_ex_flush: 1'b0};
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and stage control outputs of the stall sequencer.
// Performance counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ID_EXmemRead;
    logic [4:0]       ID_EXrd;
    logic [4:0]       IF_IDrs1;
    logic [4:0]       IF_IDrs2;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             PCwrite;
    logic             IF_IDwrite;
    logic             ID_EXwrite;
    logic             EX_MEMwrite;
    logic             IF_IDflush;
    logic             ID_EXflush;
    logic             mem_timeout;
    logic [1:0]       ctrl_state;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    // Pipeline side: supplies hazard sources, consumes enables and flushes.
    modport master (
        output ID_EXmemRead, ID_EXrd, IF_IDrs1, IF_IDrs2, branch_taken, mem_req, mem_ready,
        input  PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, IF_IDflush, ID_EXflush,
        input  mem_timeout, ctrl_state
`ifdef PIPE_PERF_CNT_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  ID_EXmemRead, ID_EXrd, IF_IDrs1, IF_IDrs2, branch_taken, mem_req, mem_ready,
        output PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, IF_IDflush, ID_EXflush,
        output mem_timeout, ctrl_state
`ifdef PIPE_PERF_CNT_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic       mem_read_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    output logic       lu_hazard_o
);
    assign lu_hazard_o = mem_read_i && (rd_i != REG_X0) && ((rd_i == rs1_i) || (rd_i == rs2_i));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline (RUN / MEM_WAIT / HALT).
// Define PIPE_PERF_CNT_EN to add saturating stall_cycles / flush_events counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_stall_ctrl_if.slave ctrl
);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be in 1..255");
    end

    ctrl_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  lu_hazard;
    logic                  mem_stall;
    logic                  halted;
    stage_ctrl_t           sc;

    load_use_detect u_lu (
        .mem_read_i  (ctrl.ID_EXmemRead),
        .rd_i        (ctrl.ID_EXrd),
        .rs1_i       (ctrl.IF_IDrs1),
        .rs2_i       (ctrl.IF_IDrs2),
        .lu_hazard_o (lu_hazard)
    );

    // A zero-wait access (req with ready) is not a stall.
    assign mem_stall = ctrl.mem_req && !ctrl.mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_CNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (ctrl.mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            default: state_d = ST_HALT;  // unused encoding 3 behaves as HALT
        endcase
    end

    always_comb begin
        sc     = ctrl_advance();
        halted = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        sc = ctrl_freeze();
                    end else if (ctrl.branch_taken) begin
                        sc.if_id_flush = 1'b1;
                        sc.id_ex_flush = 1'b1;
                    end else if (lu_hazard) begin
                        sc.pc_we       = 1'b0;
                        sc.if_id_we    = 1'b0;
                        sc.id_ex_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!ctrl.mem_ready) sc = ctrl_freeze();
                end
                default: begin
                    sc     = ctrl_freeze();
                    halted = 1'b1;
                end
            endcase
        end
    end

    assign ctrl.PCwrite     = sc.pc_we;
    assign ctrl.IF_IDwrite  = sc.if_id_we;
    assign ctrl.ID_EXwrite  = sc.id_ex_we;
    assign ctrl.EX_MEMwrite = sc.ex_mem_we;
    assign ctrl.IF_IDflush  = sc.if_id_flush;
    assign ctrl.ID_EXflush  = sc.id_ex_flush;
    assign ctrl.mem_timeout = timeout_q || halted;
    assign ctrl.ctrl_state  = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!sc.pc_we && !halted)                   stall_cnt_q <= sat_inc(stall_cnt_q);
            if ((state_q == ST_RUN) && sc.if_id_flush)  flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign ctrl.stall_cycles = stall_cnt_q;
    assign ctrl.flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with MEM_TIMEOUT=4.
// Control vector order: {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, IF_IDflush, ID_EXflush}.
module tb_pipeline_stall_ctrl;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    pipeline_stall_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] V_RUN    = 6'b111100;
    localparam logic [5:0] V_FREEZE = 6'b000000;
    localparam logic [5:0] V_LU     = 6'b001101;
    localparam logic [5:0] V_BR     = 6'b111111;

    function automatic logic [5:0] ctl_vec();
        return {bus.PCwrite, bus.IF_IDwrite, bus.ID_EXwrite, bus.EX_MEMwrite,
                bus.IF_IDflush, bus.ID_EXflush};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br, input logic req, input logic rdy);
        bus.ID_EXmemRead = mr;
        bus.ID_EXrd      = rd;
        bus.IF_IDrs1     = rs1;
        bus.IF_IDrs2     = rs2;
        bus.branch_taken = br;
        bus.mem_req      = req;
        bus.mem_ready    = rdy;
        #2;
    endtask

    initial begin
        reset = 1'b1;
        // Reset overrides a live load-use hazard.
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        check("reset_ctl", 32'(ctl_vec()), 32'(V_RUN));
        cyc();
        cyc();
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        check("reset_ctl_held", 32'(ctl_vec()), 32'(V_RUN));
        check("reset_state", 32'(bus.ctrl_state), 32'd0);
        check("reset_timeout", 32'(bus.mem_timeout), 32'd0);

        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("idle_ctl", 32'(ctl_vec()), 32'(V_RUN));

        // Load-use on rs2, one bubble, then clear.
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        check("lu_rs2", 32'(ctl_vec()), 32'(V_LU));
        cyc();
        drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        check("lu_after", 32'(ctl_vec()), 32'(V_RUN));
        check("lu_state", 32'(bus.ctrl_state), 32'd0);
        drive(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b0);
        check("lu_rs1", 32'(ctl_vec()), 32'(V_LU));
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_x0", 32'(ctl_vec()), 32'(V_RUN));
        drive(1'b1, 5'd9, 5'd8, 5'd10, 1'b0, 1'b0, 1'b0);
        check("lu_nomatch", 32'(ctl_vec()), 32'(V_RUN));
        cyc();

        // Branch beats load-use, single cycle.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        check("br_over_lu", 32'(ctl_vec()), 32'(V_BR));
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("br_after", 32'(ctl_vec()), 32'(V_RUN));

        // Memory wait: ready low 3 cycles, branch ignored in MEM_WAIT.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("mw_run_stall", 32'(ctl_vec()), 32'(V_FREEZE));
        check("mw_run_state", 32'(bus.ctrl_state), 32'd0);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        check("mw_w1_ctl", 32'(ctl_vec()), 32'(V_FREEZE));
        check("mw_w1_state", 32'(bus.ctrl_state), 32'd1);
        cyc();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        check("mw_w2_ctl", 32'(ctl_vec()), 32'(V_FREEZE));
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("mw_ready_ctl", 32'(ctl_vec()), 32'(V_RUN));
        check("mw_ready_state", 32'(bus.ctrl_state), 32'd1);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("mw_back_state", 32'(bus.ctrl_state), 32'd0);
        check("mw_back_ctl", 32'(ctl_vec()), 32'(V_RUN));

        // Zero-wait access falls through to branch handling.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        check("zw_branch", 32'(ctl_vec()), 32'(V_BR));
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("zw_state", 32'(bus.ctrl_state), 32'd0);

        // Timeout: RUN stall cycle, four MEM_WAIT cycles, then HALT.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            check($sformatf("to_wait%0d_state", i), 32'(bus.ctrl_state), 32'd1);
            check($sformatf("to_wait%0d_flag", i), 32'(bus.mem_timeout), 32'd0);
            cyc();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("halt_state", 32'(bus.ctrl_state), 32'd2);
        check("halt_flag", 32'(bus.mem_timeout), 32'd1);
        check("halt_ctl", 32'(ctl_vec()), 32'(V_FREEZE));
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        check("halt_sticky_state", 32'(bus.ctrl_state), 32'd2);
        check("halt_sticky_flag", 32'(bus.mem_timeout), 32'd1);
        check("halt_sticky_ctl", 32'(ctl_vec()), 32'(V_FREEZE));
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("halt_reset_ctl", 32'(ctl_vec()), 32'(V_RUN));
        cyc();
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("post_reset_state", 32'(bus.ctrl_state), 32'd0);
        check("post_reset_flag", 32'(bus.mem_timeout), 32'd0);

`ifdef PIPE_PERF_CNT_EN
        // One load-use stall, one branch, three memory wait cycles.
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("perf_stall", bus.stall_cycles, 32'd4);
        check("perf_flush", bus.flush_events, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
